// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning HI/LO; MULT/DIV results land WIDTH+1 edges after accept, MTHI/MTLO at the accept edge.
// No backpressure on results; new requests are accepted only while busy is low and are dropped otherwise.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opnd;
  logic                 is_div, neg_lo, neg_hi, dbz;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step, div_step, prod;
  logic [WIDTH:0]       div_shift;
  logic [WIDTH-1:0]     div_sub, quo, rem;
  logic                 div_ge;

  // op[0]=0 marks the signed variants (MULT, DIV)
  assign a_mag = (!op[0] && a[WIDTH-1]) ? -a : a;
  assign b_mag = (!op[0] && b[WIDTH-1]) ? -b : b;

  // Multiply: multiplier sits in acc low half and is consumed LSB first
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
  assign mul_step = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                           : {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1:1]};

  // Divide: acc high half is the partial remainder, low half shifts dividend out and quotient in
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_sub   = div_shift[WIDTH-1:0] - opnd;
  assign div_step  = div_ge ? {div_sub, acc[WIDTH-2:0], 1'b1}
                            : {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};

  assign prod = neg_lo ? -acc : acc;
  assign quo  = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !op[2]) state_nxt = CALC;
      CALC:    if (cnt == CW'(WIDTH-1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      acc         <= '0;
      opnd        <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      dbz         <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state == FINISH);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start && op == 3'b100) hi <= a;
          if (start && op == 3'b101) lo <= a;
          if (start && !op[2]) begin
            is_div <= op[1];
            dbz    <= op[1] && (b == '0);
            neg_lo <= !op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi <= !op[0] && a[WIDTH-1];
            opnd   <= op[1] ? b_mag : a_mag;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          acc <= is_div ? div_step : mul_step;
        end
        FINISH: begin
          // A zero divisor leaves the dividend in the remainder, so hi already equals a
          if (is_div) begin
            lo <= dbz ? '1 : quo;
            hi <= rem;
          end else begin
            {hi, lo} <= prod;
          end
          div_by_zero <= dbz;
        end
        default: ;
      endcase
    end
  end

endmodule
